// File: rtl/idct_pkg.sv
// Shared constants for the 8x8 transform datapath.
package idct_pkg;
  localparam int BLOCK_N       = 8;
  localparam int BLOCK_SZ      = BLOCK_N * BLOCK_N;
  localparam int LEVEL_SHIFT   = 128;
  localparam int FRAC_BITS_DEF = 8;
  localparam int PIX_W         = 8;
  localparam int IDX_W         = $clog2(BLOCK_N);
  localparam int CNT_W         = 2 * IDX_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SZ - 1);
endpackage

// File: rtl/pixel_block_buffer.sv
// Two banks of 64 raw pixels: one synchronous write port, one asynchronous read port.
module pixel_block_buffer
  import idct_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic             wsel,
  input  logic [CNT_W-1:0] waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             rsel,
  input  logic [CNT_W-1:0] raddr,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem [0:2*BLOCK_SZ-1];

  // Pixel storage is data only; it carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[{wsel, waddr}] <= wdata;
  end

  assign rdata = mem[{rsel, raddr}];
endmodule

// File: rtl/pixel_input_loader.sv
// Pixel front end: level-shift, ping-pong 8x8 block buffering, coefficient streaming.
module pixel_input_loader
  import idct_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int OUT_W     = 32,
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PIX_W-1:0]        pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic                    pix_last,
  output logic signed [OUT_W-1:0] coef_out,
  output logic                    coef_valid,
  input  logic                    coef_ready,
  output logic                    coef_last,
  output logic [IDX_W-1:0]        coef_row,
  output logic [IDX_W-1:0]        coef_col,
  output logic                    sync_err
);
  localparam logic signed [PIX_W:0] LVL = (PIX_W+1)'(LEVEL_SHIFT);

  logic [CNT_W-1:0] wr_cnt, rd_cnt, rd_addr;
  logic             wr_sel, rd_sel;
  logic [1:0]       bank_full, bank_full_nxt;
  logic             wr_fire, rd_fire, wr_done, rd_done;
  logic [PIX_W-1:0] rd_pix;

  // Unsigned pixel to signed fixed point; the range always fits, so no saturation.
  function automatic logic signed [OUT_W-1:0] scale_pix(input logic [PIX_W-1:0] p);
    logic signed [PIX_W:0] d;
    d = $signed({1'b0, p}) - LVL;
    return OUT_W'(d) <<< FRAC_BITS;
  endfunction

  assign pix_ready  = !rst && !bank_full[wr_sel];
  assign coef_valid = bank_full[rd_sel];
  assign wr_fire    = pix_valid && pix_ready;
  assign rd_fire    = coef_valid && coef_ready;
  assign wr_done    = wr_fire && (wr_cnt == CNT_LAST);
  assign rd_done    = rd_fire && (rd_cnt == CNT_LAST);

  // Column-major emission just swaps the row and column halves of the count.
  assign rd_addr   = TRANSPOSE ? {rd_cnt[IDX_W-1:0], rd_cnt[CNT_W-1:IDX_W]} : rd_cnt;
  assign coef_row  = rd_addr[CNT_W-1:IDX_W];
  assign coef_col  = rd_addr[IDX_W-1:0];
  assign coef_last = coef_valid && (rd_cnt == CNT_LAST);
  assign coef_out  = coef_valid ? scale_pix(rd_pix) : '0;

  // Fill and drain touch different banks, so both updates can land in one cycle.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_done) bank_full_nxt[wr_sel] = 1'b1;
    if (rd_done) bank_full_nxt[rd_sel] = 1'b0;
  end

  // Bank occupancy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bank_full <= 2'b00;
    else     bank_full <= bank_full_nxt;
  end

  // Write-side counter, bank select and sticky framing check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt   <= '0;
      wr_sel   <= 1'b0;
      sync_err <= 1'b0;
    end else if (wr_fire) begin
      if (pix_last != (wr_cnt == CNT_LAST)) sync_err <= 1'b1;
      if (wr_done) begin
        wr_cnt <= '0;
        wr_sel <= !wr_sel;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // Read-side counter and bank select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      rd_sel <= 1'b0;
    end else if (rd_fire) begin
      if (rd_done) begin
        rd_cnt <= '0;
        rd_sel <= !rd_sel;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  pixel_block_buffer u_buf (
    .clk   (clk),
    .we    (wr_fire),
    .wsel  (wr_sel),
    .waddr (wr_cnt),
    .wdata (pix_in),
    .rsel  (rd_sel),
    .raddr (rd_addr),
    .rdata (rd_pix)
  );
endmodule

// File: tb/tb_pixel_input_loader.sv
module tb_pixel_input_loader;
  localparam int FB = 8;
  localparam int OW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] pix_in;
  logic pix_valid, pix_last, coef_ready;

  logic                 pr  [2];
  logic signed [OW-1:0] co  [2];
  logic                 cv  [2];
  logic                 cl  [2];
  logic [2:0]           row [2];
  logic [2:0]           col [2];
  logic                 se  [2];

  always #5 clk = ~clk;

  pixel_input_loader #(.FRAC_BITS(FB), .OUT_W(OW), .TRANSPOSE(1'b0)) u_ras (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pr[0]),
    .pix_last(pix_last), .coef_out(co[0]), .coef_valid(cv[0]), .coef_ready(coef_ready),
    .coef_last(cl[0]), .coef_row(row[0]), .coef_col(col[0]), .sync_err(se[0]));

  pixel_input_loader #(.FRAC_BITS(FB), .OUT_W(OW), .TRANSPOSE(1'b1)) u_tr (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pr[1]),
    .pix_last(pix_last), .coef_out(co[1]), .coef_valid(cv[1]), .coef_ready(coef_ready),
    .coef_last(cl[1]), .coef_row(row[1]), .coef_col(col[1]), .sync_err(se[1]));

  int nchk = 0;
  int nerr = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pq holds the pixels of every complete, not yet drained block, oldest first.
  logic [7:0] pq[$];
  logic [7:0] cur [64];
  int  wcnt = 0;
  int  k = 0;
  bit  m_sync = 1'b0;
  bit  pfire = 1'b0;
  bit  cfire = 1'b0;

  function automatic int nblocks();
    return pq.size() / 64;
  endfunction

  function automatic int out_index(input int t, input int n);
    return (t == 1) ? ((n % 8) * 8 + n / 8) : n;
  endfunction

  function automatic int scaled(input int p);
    return (p - 128) * (1 << FB);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pq.delete();
      wcnt = 0; k = 0; m_sync = 1'b0; pfire = 1'b0; cfire = 1'b0;
    end else begin
      int nb;
      nb = nblocks();
      pfire = pix_valid && (nb < 2);
      cfire = coef_ready && (nb > 0);
      if (cfire) begin
        k++;
        if (k == 64) begin
          repeat (64) void'(pq.pop_front());
          k = 0;
        end
      end
      if (pfire) begin
        if (pix_last != (wcnt == 63)) m_sync = 1'b1;
        cur[wcnt] = pix_in;
        wcnt++;
        if (wcnt == 64) begin
          for (int i = 0; i < 64; i++) pq.push_back(cur[i]);
          wcnt = 0;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int t = 0; t < 2; t++) begin
        if (rst) begin
          chk("rst_pix_ready", pr[t], 0);
          chk("rst_coef_valid", cv[t], 0);
          chk("rst_coef_out", longint'(co[t]), 0);
          chk("rst_coef_last", cl[t], 0);
          chk("rst_coef_row", row[t], 0);
          chk("rst_coef_col", col[t], 0);
          chk("rst_sync_err", se[t], 0);
        end else begin
          int nb, idx;
          nb = nblocks();
          chk("pix_ready", pr[t], (nb < 2) ? 1 : 0);
          chk("coef_valid", cv[t], (nb > 0) ? 1 : 0);
          chk("sync_err", se[t], m_sync);
          if (nb > 0) begin
            idx = out_index(t, k);
            chk("coef_out", longint'(co[t]), scaled(int'(pq[idx])));
            chk("coef_row", row[t], idx / 8);
            chk("coef_col", col[t], idx % 8);
            chk("coef_last", cl[t], (k == 63) ? 1 : 0);
          end else begin
            chk("coef_out_idle", longint'(co[t]), 0);
            chk("coef_last_idle", cl[t], 0);
          end
        end
      end
    end
  end

  // Capture accepted coefficients for the explicit sequence checks.
  int cap0[$];
  int cap1[$];
  always @(negedge clk) begin
    if (!rst && coef_ready) begin
      if (cv[0]) cap0.push_back(int'(co[0]));
      if (cv[1]) cap1.push_back(int'(co[1]));
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0] pix;
    int         exp;
  } vec_t;
  vec_t tbl [8];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_pix(input logic [7:0] p, input logic last);
    int waited;
    pix_in = p; pix_last = last; pix_valid = 1'b1;
    waited = 0;
    do begin
      tick(1);
      waited++;
    end while (!pfire && waited < 2000);
    if (!pfire) chk("send_timeout", 0, 1);
    pix_valid = 1'b0; pix_last = 1'b0;
  endtask

  // mode 0: ramp, 1: table values, 2: random. Optional random idle gaps.
  task automatic send_block(input int mode, input int last_pos, input bit gaps);
    logic [7:0] p;
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0:       p = 8'(i);
        1:       p = tbl[i % 8].pix;
        default: p = 8'($urandom_range(0, 255));
      endcase
      if (gaps && $urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
      send_pix(p, i == last_pos);
    end
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while (pq.size() != 0 && waited < 3000) begin
      tick(1);
      waited++;
    end
    chk("drain_done", pq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    logic [7:0] eb;
    logic signed [OW-1:0] hold;
    bit done;

    tbl[0] = '{8'd0,   -32768};
    tbl[1] = '{8'd128,  0};
    tbl[2] = '{8'd255,  32512};
    tbl[3] = '{8'd63,  -16640};
    tbl[4] = '{8'd1,   -32512};
    tbl[5] = '{8'd127, -256};
    tbl[6] = '{8'd200,  18432};
    tbl[7] = '{8'd64,  -16384};

    pix_in = 8'd0; pix_valid = 1'b0; pix_last = 1'b0; coef_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #2 mon_en = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("pix_ready_after_rst", pr[0], 1);
    tick(1);

    // Table-driven extremes through the raster instance.
    coef_ready = 1'b1;
    cap0.delete(); cap1.delete();
    send_block(1, 63, 1'b0);
    wait_drain();
    chk("tbl_count", cap0.size(), 64);
    for (int i = 0; i < 64 && i < cap0.size(); i++) begin
      v = cap0[i];
      chk("tbl_coef", v, tbl[i % 8].exp);
      eb = tbl[i % 8].pix - 8'd128;
      chk("tbl_int_bits", v[15:8], eb);
    end

    // Raster ramp: raster and column-major order.
    cap0.delete(); cap1.delete();
    send_block(0, 63, 1'b0);
    wait_drain();
    chk("ramp_count_ras", cap0.size(), 64);
    chk("ramp_count_tr", cap1.size(), 64);
    for (int i = 0; i < 64 && i < cap0.size() && i < cap1.size(); i++) begin
      chk("ramp_ras", cap0[i], (i - 128) * 256);
      chk("ramp_tr", cap1[i], ((i % 8) * 8 + i / 8 - 128) * 256);
    end
    chk("ramp_sync_err", se[0], 0);

    // Back-pressure: three blocks with the consumer stalled.
    coef_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 3; b++) send_block(2, 63, 1'b0);
      end
      begin
        int waited;
        waited = 0;
        while (pq.size() < 128 && waited < 1000) begin
          tick(1);
          waited++;
        end
        chk("bp_two_blocks", pq.size(), 128);
        tick(5);
        chk("bp_pix_ready_low", pr[0], 0);
        hold = co[0];
        tick(10);
        chk("bp_coef_stable", longint'(co[0]), longint'(hold));
        chk("bp_wcnt_stalled", wcnt, 0);
        coef_ready = 1'b1;
      end
    join
    wait_drain();

    // Random pixels, random gaps, random consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 4; b++) send_block(2, 63, 1'b1);
        done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!done && n < 20000) begin
          coef_ready = $urandom_range(0, 1);
          tick(1);
          n++;
        end
      end
    join
    coef_ready = 1'b1;
    wait_drain();

    // Misplaced pix_last is sticky.
    send_block(0, 10, 1'b0);
    tick(1);
    chk("sync_err_set", se[0], 1);
    wait_drain();
    tick(5);
    chk("sync_err_sticky", se[1], 1);

    // Reset mid-drain with a partial block pending, then a clean block.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    send_block(2, 63, 1'b0);
    for (int i = 0; i < 20; i++) send_pix(8'(255 - i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", cv[0], 0);
    chk("mid_rst_coef", longint'(co[0]), 0);
    chk("mid_rst_ready", pr[0], 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    cap0.delete(); cap1.delete();
    send_block(0, 63, 1'b0);
    wait_drain();
    chk("post_rst_count", cap0.size(), 64);
    for (int i = 0; i < 64 && i < cap0.size(); i++)
      chk("post_rst_ramp", cap0[i], (i - 128) * 256);
    chk("post_rst_sync_err", se[0], 0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
